// File: rtl/noc_mcast_scheduler.sv
// Multicast crossbar scheduler for the 5-port NoC router.
// Grants one input at a time (round-robin), looks the flit's destination up in a
// runtime-programmable mask table, then offers the held flit to every selected
// output in parallel until each one has taken it.
module noc_mcast_scheduler #(
    parameter int NPORT    = 5,
    parameter int DATA_W   = 42,
    parameter int ADDR_LSB = 32,
    parameter int ADDR_W   = 7,
    parameter int RT_DEPTH = 128,
    parameter int CNT_W    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NPORT-1:0]        i_in_valid,
    output logic [NPORT-1:0]        o_in_ready,
    input  logic [NPORT*DATA_W-1:0] i_in_data,
    output logic [NPORT-1:0]        o_out_valid,
    input  logic [NPORT-1:0]        i_out_ready,
    output logic [DATA_W-1:0]       o_out_data,
    input  logic                    i_cfg_we,
    input  logic [ADDR_W-1:0]       i_cfg_addr,
    input  logic [NPORT-1:0]        i_cfg_mask,
    output logic                    o_busy,
    output logic [CNT_W-1:0]        o_drop_cnt
);

    localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [NPORT-1:0]    pending_q, pending_d;
    logic [CNT_W-1:0]    drop_q, drop_d;

    logic [NPORT-1:0]    rt_q [RT_DEPTH];
    logic [NPORT-1:0]    rt_rd;

    logic [DATA_W-1:0]   in_word [NPORT];
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_vld;

    // Unpack the flat input bus and build the one-hot pop strobe (only ever in IDLE)
    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            assign in_word[gi]    = i_in_data[gi*DATA_W +: DATA_W];
            assign o_in_ready[gi] = (state_q == IDLE) && grant_vld &&
                                    (grant_idx == PTR_W'(gi));
        end
    endgenerate

    // Round-robin pick: first valid port scanning cyclically from ptr+1.
    // The loop runs from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        logic [PTR_W:0] cand;
        cand      = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = NPORT; k >= 1; k--) begin
            cand = (PTR_W+1)'(ptr_q) + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NPORT)) begin
                cand = cand - (PTR_W+1)'(NPORT);
            end
            if (i_in_valid[cand[PTR_W-1:0]]) begin
                grant_idx = cand[PTR_W-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    // Table read addressed by the held flit; a same-cycle write lands after this read
    assign rt_rd = rt_q[hold_q[ADDR_LSB +: ADDR_W]];

    // Next-state and output decode for IDLE -> LOOKUP -> SEND
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        pending_d   = pending_q;
        drop_d      = drop_q;
        o_out_valid = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    hold_d  = in_word[grant_idx];
                    ptr_d   = grant_idx;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                pending_d = rt_rd;
                if (rt_rd == '0) begin
                    // Unroutable flit: discard and count, saturating
                    if (drop_q != '1) begin
                        drop_d = drop_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end else begin
                    state_d = SEND;
                end
            end
            SEND: begin
                // Each output keeps valid until its own handshake
                o_out_valid = pending_q;
                pending_d   = pending_q & ~i_out_ready;
                if (pending_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state registers; reset abandons any held flit silently
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_W'(NPORT - 1);
            hold_q    <= '0;
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    // Routing table: cleared on reset, writable in any state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RT_DEPTH; i++) begin
                rt_q[i] <= '0;
            end
        end else if (i_cfg_we) begin
            rt_q[i_cfg_addr] <= i_cfg_mask;
        end
    end

    assign o_out_data = hold_q;
    assign o_busy     = (state_q != IDLE);
    assign o_drop_cnt = drop_q;

endmodule

// File: doc/noc_mcast_scheduler.md
Name: noc_mcast_scheduler

Overview:
Cycle-level scheduler for the 5-port neuromorphic NoC router crossbar. It arbitrates round-robin among the N/S/E/W/PE input streams and accepts one 42-bit flit at a time. It looks up the flit's destination address in a runtime-writable multicast routing table and presents the flit to every output in the resulting mask in parallel. It holds the flit until all selected outputs have accepted it. It sits between the per-port input FIFOs and the per-port output FIFOs, replacing hard-coded routing with a configurable table.

Parameters:
NPORT, 5, number of ports; index 0=N, 1=S, 2=E, 3=W, 4=PE
DATA_W, 42, flit width
ADDR_LSB, 32, LSB of destination address field in flit
ADDR_W, 7, address field width (flit bits [38:32])
RT_DEPTH, 128, routing table entries (2**ADDR_W)
CNT_W, 16, drop counter width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; one clock; synchronous, active-low
i_in_valid  in  NPORT  per-input flit valid (from input FIFO m_axis_tvalid)
o_in_ready  out  NPORT  per-input pop (to input FIFO m_axis_tready)
i_in_data  in  NPORT*DATA_W  input flits; port p at [p*DATA_W +: DATA_W]
o_out_valid  out  NPORT  per-output valid (to output FIFO s_axis_tvalid)
i_out_ready  in  NPORT  per-output ready (from output FIFO s_axis_tready)
o_out_data  out  DATA_W  held flit, common to all outputs
i_cfg_we  in  1  routing table write strobe
i_cfg_addr  in  ADDR_W  table entry to write
i_cfg_mask  in  NPORT  output mask; bit p = forward to port p
o_busy  out  1  high whenever state != IDLE
o_drop_cnt  out  CNT_W  flits discarded due to all-zero mask, saturating

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - state=IDLE; all o_in_ready=0 and o_out_valid=0; o_busy=0; o_drop_cnt=0.
  - RR pointer=NPORT-1, so port 0 has first priority.
  - Pending mask=0; all RT entries=0.
  - Reset mid-operation discards the held flit; nothing is signalled.
- States: IDLE, LOOKUP, SEND.
- IDLE:
  - If any i_in_valid is set, grant g = first set bit scanning cyclically from ptr+1.
  - In the same cycle, o_in_ready[g]=1 (combinational, one-hot, IDLE only). Latch i_in_data[g] into the hold register; ptr<=g; go to LOOKUP.
  - If no i_in_valid is set, stay in IDLE with o_in_ready=0.
- LOOKUP (1 cycle): pending <= RT[hold[ADDR_LSB +: ADDR_W]].
  - Mask==0: o_drop_cnt increments, saturating at all-ones; return to IDLE.
  - Otherwise go to SEND.
- SEND:
  - o_out_valid = pending; o_out_data = hold, stable for the whole state.
  - Each cycle, pending <= pending & ~i_out_ready.
  - A valid bit never drops before its own handshake (AXI-Stream compliant).
  - When (pending & ~i_out_ready)==0, go to IDLE.
  - Loopback (output == source port) is permitted.
- Latency: flit popped at cycle T; outputs valid at T+2. Minimum 3 cycles per flit; no input is popped while state != IDLE.
- Routing table:
  - Write at posedge when i_cfg_we=1, in any state.
  - A lookup and a write to the same address in the same cycle: the lookup uses the old value. The new value applies from the next cycle.
  - A write during SEND does not alter the in-flight pending mask.
- Fairness: a continuously valid port waits at most NPORT-1 grants.

Test Plan:
1. Write RT[5]=5'b00110. Drive input 0 with addr 5, data 42'h0_0005_1234_5678; all out ready -> o_in_ready[0] pulses at T, o_out_valid=5'b00110 at T+2 with that data, IDLE at T+3.
2. RT[9]=5'b10001, input 2 addr 9. i_out_ready[0]=1, i_out_ready[4]=0 for 4 cycles then 1 -> o_out_valid goes 10001 then 10000 for 4 cycles, then 0. o_in_ready stays 0 throughout. o_busy stays high until IDLE.
3. Program all addrs to 5'b00001. Hold all 5 inputs valid with distinct payloads -> grant order 0,1,2,3,4,0, one grant every 3 cycles, payloads appear in that order.
4. Input 3 addr 7 with RT[7]=0 -> no o_out_valid, o_drop_cnt 0->1. Force o_drop_cnt to 16'hFFFF, send one more such flit -> it stays 16'hFFFF.
5. Assert i_rst_n=0 for one cycle during SEND -> next cycle o_out_valid=0, state IDLE. Re-send to a previously programmed addr -> dropped (RT cleared). First grant goes to port 0 when all inputs are valid.
6. i_cfg_we writes RT[5]=5'b01000 in the LOOKUP cycle of a flit to addr 5 (old 5'b00110) -> that flit goes to ports 1,2; the next flit to addr 5 goes to port 3 only.
